// File: rtl/regfile_pkg.sv
// Shared types and defaults for the 2-read/1-write register file.
// Pure declarations: no latency, no backpressure.
package regfile_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_DEPTH  = 8;

    function automatic int addr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// Clear sequencer: walks the array zeroing one entry per cycle.
// Busy for exactly DEPTH cycles after a request; requests while busy are ignored.
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = addr_width(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_req,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_idx
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    clr_state_t        state, state_nxt;
    logic [ADDR_W-1:0] idx, idx_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        case (state)
            IDLE: begin
                if (clr_req) begin
                    state_nxt = CLEAR;
                    idx_nxt   = '0;
                end
            end
            CLEAR: begin
                if (idx == LAST_IDX) begin
                    state_nxt = IDLE;
                    idx_nxt   = '0;
                end else begin
                    idx_nxt = idx + ADDR_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy    = (state == CLEAR);
    assign clr_we  = (state == CLEAR);
    assign clr_idx = idx;

endmodule

// File: rtl/regfile_2r1w.sv
// Register file, 1 write + 2 registered read ports with write-first bypass and bulk clear.
// Read latency 1 cycle; no backpressure: writes during a clear or out of range are dropped and flagged.
module regfile_2r1w
    import regfile_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int ADDR_W  = addr_width(DEPTH),
    parameter bit R0_ZERO = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_err,
    input  logic              rd_en_a,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    output logic              rd_valid_a,
    input  logic              rd_en_b,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              rd_valid_b,
    input  logic              clr_req,
    output logic              busy
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic              clr_we;
    logic [ADDR_W-1:0] clr_idx;
    logic              wr_hit;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    regfile_clear_seq #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_req (clr_req),
        .busy    (busy),
        .clr_we  (clr_we),
        .clr_idx (clr_idx)
    );

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return int'(a) < DEPTH;
    endfunction

    assign wr_hit = wr_en && !busy && in_range(wr_addr) && !(R0_ZERO && (wr_addr == '0));

    // The clear owns the single write port while busy; user writes are blocked then anyway.
    assign mem_we    = clr_we | wr_hit;
    assign mem_waddr = clr_we ? clr_idx : wr_addr;
    assign mem_wdata = clr_we ? '0 : wr_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // A clear is presented as atomic, so any read while busy sees zero.
    function automatic logic [DATA_W-1:0] read_val(input logic [ADDR_W-1:0] a);
        if (busy || !in_range(a) || (R0_ZERO && (a == '0))) return '0;
        if (wr_hit && (wr_addr == a)) return wr_data;
        return mem[a];
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_a  <= '0;
            rd_data_b  <= '0;
            rd_valid_a <= 1'b0;
            rd_valid_b <= 1'b0;
            wr_err     <= 1'b0;
        end else begin
            rd_valid_a <= rd_en_a;
            rd_valid_b <= rd_en_b;
            if (rd_en_a) rd_data_a <= read_val(rd_addr_a);
            if (rd_en_b) rd_data_b <= read_val(rd_addr_b);
            wr_err <= wr_en && (busy || !in_range(wr_addr));
        end
    end

endmodule

// File: tb/tb_regfile_2r1w.sv
// Two configurations (DEPTH 8 plain, DEPTH 6 with R0 hard-wired to zero) driven by
// directed then random traffic, checked against an abstract register-array model.
module tb_regfile_2r1w;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int n_done = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Value a read should return, straight from the register-file rules.
    function automatic logic [15:0] ref_read(input bit clearing, input int addr, input int depth,
                                             input bit r0, input bit wok, input int waddr,
                                             input logic [15:0] wdata, input logic [15:0] stored);
        if (clearing || addr >= depth || (r0 && addr == 0)) return 16'h0;
        if (wok && waddr == addr) return wdata;
        return stored;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : cfg
        localparam int D  = (g == 0) ? 8 : 6;
        localparam bit R0 = (g == 1);

        logic        rst_n     = 1'b1;
        logic        wr_en     = 1'b0;
        logic [2:0]  wr_addr   = '0;
        logic [15:0] wr_data   = '0;
        logic        rd_en_a   = 1'b0;
        logic [2:0]  rd_addr_a = '0;
        logic        rd_en_b   = 1'b0;
        logic [2:0]  rd_addr_b = '0;
        logic        clr_req   = 1'b0;
        logic        wr_err, busy, rd_valid_a, rd_valid_b;
        logic [15:0] rd_data_a, rd_data_b;

        regfile_2r1w #(
            .DATA_W  (16),
            .DEPTH   (D),
            .R0_ZERO (R0)
        ) dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .wr_en      (wr_en),
            .wr_addr    (wr_addr),
            .wr_data    (wr_data),
            .wr_err     (wr_err),
            .rd_en_a    (rd_en_a),
            .rd_addr_a  (rd_addr_a),
            .rd_data_a  (rd_data_a),
            .rd_valid_a (rd_valid_a),
            .rd_en_b    (rd_en_b),
            .rd_addr_b  (rd_addr_b),
            .rd_data_b  (rd_data_b),
            .rd_valid_b (rd_valid_b),
            .clr_req    (clr_req),
            .busy       (busy)
        );

        // Model: the clear zeroes everything at once and then blocks access for D cycles.
        logic [15:0] regs [8];
        int          busy_left = 0;
        logic [15:0] qa[$];
        logic [15:0] qb[$];
        logic        exp_busy = 1'b0;
        logic        exp_err  = 1'b0;
        logic [15:0] last_a   = '0;
        logic [15:0] last_b   = '0;

        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                foreach (regs[i]) regs[i] = '0;
                busy_left = 0;
                qa.delete();
                qb.delete();
                exp_busy = 1'b0;
                exp_err  = 1'b0;
            end else begin
                bit clearing, wok;
                clearing = (busy_left != 0);
                wok      = wr_en && !clearing && int'(wr_addr) < D && !(R0 && wr_addr == 3'd0);
                exp_err  = wr_en && (clearing || int'(wr_addr) >= D);
                if (rd_en_a) qa.push_back(ref_read(clearing, int'(rd_addr_a), D, R0, wok,
                                                   int'(wr_addr), wr_data, regs[rd_addr_a]));
                if (rd_en_b) qb.push_back(ref_read(clearing, int'(rd_addr_b), D, R0, wok,
                                                   int'(wr_addr), wr_data, regs[rd_addr_b]));
                if (wok) regs[wr_addr] = wr_data;
                if (clearing) busy_left--;
                else if (clr_req) begin
                    busy_left = D;
                    foreach (regs[i]) regs[i] = '0;
                end
                exp_busy = (busy_left != 0);
            end
        end

        always @(negedge clk) begin
            if (!rst_n) begin
                last_a = '0;
                last_b = '0;
            end
            check("rd_valid_a", rd_valid_a, qa.size() != 0);
            check("rd_valid_b", rd_valid_b, qb.size() != 0);
            if (qa.size() != 0) last_a = qa.pop_front();
            if (qb.size() != 0) last_b = qb.pop_front();
            check("rd_data_a", rd_data_a, last_a);
            check("rd_data_b", rd_data_b, last_b);
            check("busy", busy, exp_busy);
            check("wr_err", wr_err, exp_err);
        end

        task automatic tick();
            @(posedge clk);
            #1;
        endtask

        task automatic idle_in();
            wr_en   = 1'b0;
            rd_en_a = 1'b0;
            rd_en_b = 1'b0;
            clr_req = 1'b0;
        endtask

        task automatic wr(input int a, input logic [15:0] d);
            wr_en   = 1'b1;
            wr_addr = 3'(a);
            wr_data = d;
        endtask

        initial begin
            #1 rst_n = 1'b0;
            repeat (2) tick();
            rst_n = 1'b1;

            wr(3, 16'h1234); tick();
            idle_in(); rd_en_a = 1'b1; rd_addr_a = 3'd3; tick();
            idle_in(); tick();

            wr(5, 16'hBEEF);
            rd_en_a = 1'b1; rd_addr_a = 3'd5;
            rd_en_b = 1'b1; rd_addr_b = 3'd5;
            tick(); idle_in();

            for (int i = 0; i < 8; i++) begin
                wr(i, 16'(16'h1111 * i)); tick();
            end
            idle_in(); clr_req = 1'b1; tick();
            clr_req = 1'b0; tick(); tick();
            wr(2, 16'hAAAA); rd_en_a = 1'b1; rd_addr_a = 3'd1; tick();
            idle_in(); repeat (8) tick();
            for (int i = 0; i < 8; i++) begin
                rd_en_a = 1'b1; rd_addr_a = 3'(i);
                rd_en_b = 1'b1; rd_addr_b = 3'(7 - i);
                tick();
            end
            idle_in();

            wr(0, 16'hFFFF); tick();
            idle_in(); rd_en_a = 1'b1; rd_addr_a = 3'd0; tick();
            idle_in(); wr(7, 16'h7777); tick();
            idle_in(); rd_en_a = 1'b1; rd_addr_a = 3'd7; tick();
            idle_in();

            clr_req = 1'b1; tick();
            clr_req = 1'b0; tick(); tick();
            #1 rst_n = 1'b0;
            #1;
            check("reset_busy", busy, 0);
            check("reset_rd_data_a", rd_data_a, 0);
            check("reset_rd_valid_a", rd_valid_a, 0);
            check("reset_wr_err", wr_err, 0);
            tick();
            rst_n = 1'b1;
            wr(4, 16'h5A5A); tick();
            idle_in(); rd_en_a = 1'b1; rd_addr_a = 3'd4; rd_en_b = 1'b1; rd_addr_b = 3'd4; tick();
            idle_in();

            for (int i = 0; i < 8; i++) begin
                wr(i, 16'(16'h0101 * (i + 1))); tick();
            end
            idle_in();
            for (int i = 0; i < 8; i++) begin
                rd_en_a = 1'b1; rd_addr_a = 3'(i); tick();
            end
            idle_in(); repeat (3) tick();

            repeat (1500) begin
                wr_en     = ($urandom_range(0, 1) == 1);
                wr_addr   = 3'($urandom_range(0, 7));
                wr_data   = 16'($urandom);
                rd_en_a   = ($urandom_range(0, 2) != 0);
                rd_addr_a = ($urandom_range(0, 3) == 0) ? wr_addr : 3'($urandom_range(0, 7));
                rd_en_b   = ($urandom_range(0, 2) != 0);
                rd_addr_b = ($urandom_range(0, 3) == 0) ? wr_addr : 3'($urandom_range(0, 7));
                clr_req   = ($urandom_range(0, 29) == 0);
                tick();
            end
            idle_in(); repeat (3) tick();
            n_done++;
        end
    end

    initial begin
        int cyc;
        cyc = 0;
        while (n_done < 2 && cyc < 20000) begin
            @(posedge clk);
            cyc++;
        end
        n_cmp++;
        if (n_done < 2) begin
            n_fail++;
            $display("FAIL timeout: finished configs %0d, expected 2", n_done);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_2r1w.md
Name: regfile_2r1w

Overview:
Parametrised register file with one write port and two independent read ports. Read outputs are registered, and a same-cycle write to the read address is bypassed to the output. A built-in sequencer clears the whole array on request, one entry per cycle. It is the general-purpose register storage behind the datapath/ALU, and its reads feed the two ALU operand buses.

Parameters:
DATA_W, 16, width of each register and data port
DEPTH, 8, number of registers (>=2)
ADDR_W, $clog2(DEPTH), address width
R0_ZERO, 0, if 1: register 0 always reads 0 and writes to it are discarded

Ports:
clk  in  1  clock, all state updates on posedge
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  write request
wr_addr  in  ADDR_W  write register index
wr_data  in  DATA_W  write data
wr_err  out  1  one-cycle pulse: write dropped (busy or out-of-range address)
rd_en_a  in  1  read request, port A
rd_addr_a  in  ADDR_W  read index, port A
rd_data_a  out  DATA_W  registered read data, port A
rd_valid_a  out  1  rd_data_a updated this cycle
rd_en_b  in  1  read request, port B
rd_addr_b  in  ADDR_W  read index, port B
rd_data_b  out  DATA_W  registered read data, port B
rd_valid_b  out  1  rd_data_b updated this cycle
clr_req  in  1  request to zero all registers
busy  out  1  clear sequence in progress

Behaviour:
- Reset (rst_n=0, asynchronous):
  - all registers 0; rd_data_a/b 0; rd_valid_a/b 0; wr_err 0; busy 0.
  - FSM goes to IDLE; clear index 0.
  - Reset takes effect immediately, including in the middle of a clear.
- Write: at posedge with wr_en=1, busy=0, wr_addr<DEPTH and not (R0_ZERO && wr_addr==0), R[wr_addr]<=wr_data.
  - A write with busy=1 or wr_addr>=DEPTH is discarded and wr_err=1 the next cycle.
  - A write to address 0 with R0_ZERO=1 is discarded silently; no wr_err.
- Read latency is 1 cycle: rd_en_x=1 sampled at edge N gives rd_data_x and rd_valid_x=1 after edge N. rd_valid_x is a single-cycle pulse per request.
- With rd_en_x=0, rd_data_x holds its last value and rd_valid_x=0.
- Write-first bypass: if a valid write and a read on port x target the same address in the same cycle, rd_data_x=wr_data. Both ports may bypass at once.
- Read data rules:
  - rd_addr>=DEPTH returns 0 with rd_valid=1.
  - R0_ZERO=1 and rd_addr==0 returns 0.
  - A read with busy=1 returns 0 with rd_valid=1; the clear is treated as atomic.
- Both ports may read the same address in the same cycle and both get identical data.
- Clear FSM, states IDLE and CLEAR:
  - IDLE: clr_req=1 -> CLEAR with idx=0; busy=1 from the next cycle.
  - CLEAR: each cycle R[idx]<=0 and idx<=idx+1. When idx==DEPTH-1, zero that entry and return to IDLE; busy=0 from the next cycle.
  - busy is high for exactly DEPTH cycles.
  - clr_req while in CLEAR is ignored and does not restart the sequence.
  - clr_req and wr_en in the same IDLE cycle: the write is performed, then the clear overwrites it.
- No combinational path from inputs to any output; all outputs are registered.

Decomposition:
- Package regfile_pkg: state enum {IDLE, CLEAR}, default DATA_W/DEPTH constants, and a function returning ADDR_W from DEPTH.
- Sub-module regfile_clear_seq: FSM plus index counter; outputs busy, clr_we and clr_idx. The top level muxes clr_we/clr_idx over the write port.

Test Plan:
- Reset then write R3=0x1234, next cycle read A addr 3 -> one cycle later rd_data_a=0x1234, rd_valid_a=1 for one cycle.
- Same cycle: write R5=0xBEEF, read A addr 5 and B addr 5 -> both rd_data=0xBEEF next cycle (bypass on both ports).
- Fill R0..R7 with 0x1111*i, pulse clr_req -> busy high exactly 8 cycles; mid-clear write R2=0xAAAA gives wr_err=1; after busy drops, all reads return 0.
- R0_ZERO=1: write R0=0xFFFF -> read R0 returns 0, wr_err stays 0. DEPTH=6: write addr 7 -> wr_err=1; read addr 7 -> 0.
- Assert rst_n=0 at the 3rd cycle of a clear -> outputs 0 immediately; busy 0 after release; a new write and read works normally.
- Back-to-back reads on A with rd_en every cycle over addresses 0..7 -> 8 consecutive rd_valid pulses with in-order data; rd_data holds after rd_en drops.
